sram_bridge: RTL and testbench

SRAM_BRIDGE -- requirements
Module: sram_bridge

---
 rtl/sram_bridge_pkg.sv | 23 ++
 rtl/sram_bridge_fifo.sv | 56 +++++
 rtl/sram_bridge.sv | 193 +++++++++++++++++++
 tb/tb_sram_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the SRAM-style CPU to SDRAM bridge.
// FIFO entries carry up to MAX_ADDR_W address bits; bridge instances use ADDR_W <= MAX_ADDR_W.
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CPU_RD = 3'd1,
        CPU_WR = 3'd2,
        DL_WR  = 3'd3,
        WAIT   = 3'd4
    } state_t;

    localparam int MAX_ADDR_W = 32;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } fifo_entry_t;

    localparam logic [7:0] IDLE_DOUT = 8'h00;
    localparam logic [7:0] TMO_DOUT  = 8'hFF;

endpackage

// File: rtl/sram_bridge_fifo.sv
// Download FIFO: power-of-two depth ring buffer with a show-ahead head entry.
// A push while full is accepted only if a pop happens in the same cycle.
module sram_bridge_fifo
    import sram_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  fifo_entry_t              din,
    output fifo_entry_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/sram_bridge.sv
// CPU SRAM-strobe and ROM-download bridge onto a single-request SDRAM port.
// Optional watchdog on the WAIT state: define SRAM_BRIDGE_TIMEOUT_EN.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DL_DEPTH = 4,
    parameter int TMO_CYC  = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic              cpu_n_cs,
    input  logic              cpu_n_oe,
    input  logic              cpu_n_we,
    output logic              cpu_rdy,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_stall,
    output logic              dl_overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic              ram_rd,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic              ram_err
);

    localparam int CNT_W = $clog2(DL_DEPTH) + 1;

    logic              cs_rd, cs_wr, strobe, start_edge, dl_rise;
    logic              strobe_reg, dl_active_reg;
    logic              pend_rd_reg, pend_wr_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [7:0]        pend_din_reg;
    logic              wait_rd_reg, wait_cpu_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]        ram_din_reg, cpu_dout_reg;
    logic              overflow_reg;
    logic              cpu_busy, tmo_hit;
    state_t            state_reg, state_next;

    fifo_entry_t       fifo_din, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign cs_rd  = ~cpu_n_cs & ~cpu_n_oe;
    assign cs_wr  = ~cpu_n_cs & ~cpu_n_we;
    assign strobe = cs_rd | cs_wr;
    // Only a fresh strobe starts an access, and never during a download.
    assign start_edge = strobe & ~strobe_reg & ~dl_active;
    assign dl_rise    = dl_active & ~dl_active_reg;

    assign fifo_din.addr = MAX_ADDR_W'(dl_addr);
    assign fifo_din.data = dl_data;
    assign fifo_push     = dl_wr;
    assign fifo_pop      = (state_reg == IDLE) && (state_next == DL_WR);

    sram_bridge_fifo #(.DEPTH(DL_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    generate
        if (ADDR_W < MAX_ADDR_W) begin : g_addr_pad
            logic unused_addr_hi;
            assign unused_addr_hi = ^fifo_head.addr[MAX_ADDR_W-1:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty)                     state_next = DL_WR;
                else if (pend_wr_reg && !dl_active)  state_next = CPU_WR;
                else if (pend_rd_reg && !dl_active)  state_next = CPU_RD;
            end
            CPU_RD, CPU_WR, DL_WR: state_next = WAIT;
            WAIT:    if (ram_ready || tmo_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_rd   = (state_reg == CPU_RD);
        ram_we   = (state_reg == CPU_WR) || (state_reg == DL_WR);
        cpu_busy = pend_rd_reg || pend_wr_reg || (state_reg == CPU_RD) ||
                   (state_reg == CPU_WR) || ((state_reg == WAIT) && wait_cpu_reg);
        cpu_rdy  = dl_active || !cpu_busy;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strobe_reg    <= 1'b0;
            dl_active_reg <= 1'b0;
            pend_rd_reg   <= 1'b0;
            pend_wr_reg   <= 1'b0;
            pend_addr_reg <= '0;
            pend_din_reg  <= '0;
            wait_rd_reg   <= 1'b0;
            wait_cpu_reg  <= 1'b0;
            ram_addr_reg  <= '0;
            ram_din_reg   <= '0;
            cpu_dout_reg  <= IDLE_DOUT;
            overflow_reg  <= 1'b0;
        end else begin
            strobe_reg    <= strobe;
            dl_active_reg <= dl_active;
            if (state_reg == IDLE && (state_next == CPU_RD || state_next == CPU_WR)) begin
                pend_rd_reg <= 1'b0;
                pend_wr_reg <= 1'b0;
            end
            // A simultaneous read and write strobe is treated as a write.
            if (start_edge) begin
                pend_wr_reg   <= cs_wr;
                pend_rd_reg   <= ~cs_wr;
                pend_addr_reg <= cpu_addr;
                pend_din_reg  <= cpu_din;
            end
            if (dl_rise) begin
                pend_rd_reg <= 1'b0;
                pend_wr_reg <= 1'b0;
            end
            // Request address/data are latched once and held through WAIT.
            if (state_reg == IDLE && state_next != IDLE) begin
                wait_rd_reg  <= (state_next == CPU_RD);
                wait_cpu_reg <= (state_next != DL_WR);
                if (state_next == DL_WR) begin
                    ram_addr_reg <= fifo_head.addr[ADDR_W-1:0];
                    ram_din_reg  <= fifo_head.data;
                end else begin
                    ram_addr_reg <= pend_addr_reg;
                    ram_din_reg  <= pend_din_reg;
                end
            end
            if (state_reg == WAIT && wait_rd_reg) begin
                if (ram_ready)    cpu_dout_reg <= ram_dout;
                else if (tmo_hit) cpu_dout_reg <= TMO_DOUT;
            end
            if (dl_rise) overflow_reg <= 1'b0;
            if (dl_wr && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
        end
    end

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             err_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            tmo_cnt_reg <= (state_reg == WAIT) ? tmo_cnt_reg + 1'b1 : '0;
            if (tmo_hit) err_reg <= 1'b1;
        end
    end

    assign tmo_hit = (state_reg == WAIT) && !ram_ready &&
                     (tmo_cnt_reg == TMO_W'(TMO_CYC - 1));
    assign ram_err = err_reg;
`else
    localparam int TMO_CYC_UNUSED = TMO_CYC;
    assign tmo_hit = 1'b0;
    assign ram_err = 1'b0;
`endif

    assign cpu_dout    = cpu_dout_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_din     = ram_din_reg;
    assign dl_stall    = (fifo_count == CNT_W'(DL_DEPTH));
    assign dl_overflow = overflow_reg;

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: vector table, download/reset sequences, random CPU traffic.
// SDRAM is modelled as a byte store answering each request after a programmable delay.
module tb_sram_bridge;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif
    localparam int K_RD = 0, K_WR = 1, K_BOTH = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_n_cs, cpu_n_oe, cpu_n_we;
    logic        cpu_rdy;
    logic        dl_active, dl_wr;
    logic [22:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_stall, dl_overflow;
    logic [22:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_rd, ram_we, ram_ready, ram_err;

    always #5 clk_sys = ~clk_sys;

    sram_bridge #(.ADDR_W(23), .DL_DEPTH(4), .TMO_CYC(TMO)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_n_cs(cpu_n_cs), .cpu_n_oe(cpu_n_oe), .cpu_n_we(cpu_n_we), .cpu_rdy(cpu_rdy),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_stall(dl_stall), .dl_overflow(dl_overflow),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_rd(ram_rd), .ram_we(ram_we), .ram_ready(ram_ready), .ram_err(ram_err)
    );

    int checks = 0, failures = 0;
    int rd_pulses = 0, we_pulses = 0, both_err = 0, stable_err = 0;
    int resp_delay = 1, resp_cnt = 0;
    bit resp_busy = 0;
    logic [22:0] last_addr, held_addr;
    logic [7:0]  last_din, held_din;
    logic [30:0] wr_log[$];
    logic [7:0]  env_mem [logic [22:0]];
    logic [7:0]  ref_mem [logic [22:0]];

    function automatic logic [7:0] env_rd(input logic [22:0] a);
        return env_mem.exists(a) ? env_mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [22:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; SDRAM responder and request monitor run here.
    task automatic cycle();
        @(posedge clk_sys);
        #1;
        ram_ready = 1'b0;
        if (resp_busy) begin
            if (ram_addr !== held_addr || ram_din !== held_din) stable_err++;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    ram_ready = 1'b1;
                    resp_busy = 0;
                end
            end
        end
        if (ram_rd && ram_we) both_err++;
        if (ram_rd || ram_we) begin
            if (ram_rd) begin
                rd_pulses++;
                ram_dout = env_rd(ram_addr);
            end else begin
                we_pulses++;
                wr_log.push_back({ram_addr, ram_din});
                env_mem[ram_addr] = ram_din;
            end
            last_addr = ram_addr;
            last_din  = ram_din;
            held_addr = ram_addr;
            held_din  = ram_din;
            resp_busy = 1;
            resp_cnt  = resp_delay;
        end
    endtask

    task automatic cpu_idle();
        cpu_n_cs = 1'b1;
        cpu_n_oe = 1'b1;
        cpu_n_we = 1'b1;
    endtask

    task automatic cpu_access(input int kind, input logic [22:0] a, input logic [7:0] d,
                              input int delay, input int hold,
                              output int nrd, output int nwe, output int nlow);
        int rd0, we0;
        rd0 = rd_pulses;
        we0 = we_pulses;
        nlow = 0;
        resp_delay = delay;
        cpu_addr = a;
        cpu_din  = d;
        cpu_n_cs = 1'b0;
        cpu_n_oe = (kind == K_WR);
        cpu_n_we = (kind == K_RD);
        for (int i = 0; i < hold; i++) begin
            cycle();
            if (!cpu_rdy) nlow++;
        end
        cpu_idle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (!cpu_rdy) nlow++;
        end
        nrd = rd_pulses - rd0;
        nwe = we_pulses - we0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ram_rd"}, ram_rd, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_cpu_dout"}, cpu_dout, 8'h00);
        chk({tag, "_cpu_rdy"}, cpu_rdy, 1);
        chk({tag, "_dl_stall"}, dl_stall, 0);
        chk({tag, "_dl_overflow"}, dl_overflow, 0);
        chk({tag, "_ram_err"}, ram_err, 0);
    endtask

    typedef struct {
        int          kind;
        logic [22:0] addr;
        logic [7:0]  din;
        bit          pre;
        logic [7:0]  preval;
        int          delay;
        int          hold;
        int          exp_rd;
        int          exp_we;
        int          exp_low;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nrd, nwe, nlow, base, rd0, we0, rdy_viol, guard;
        logic [22:0] a, ea;
        logic [7:0]  d;
        logic [22:0] written[$];
        bit          seen;

        // ram_ready arrives delay cycles after the ram_rd/ram_we cycle; cpu_rdy is low delay+2 cycles.
        vecs[0] = '{K_RD,   23'h001234, 8'h00, 1'b1, 8'h5C, 4, 10, 1, 0, 6, 8'h5C};
        vecs[1] = '{K_WR,   23'h7FFFFF, 8'hA5, 1'b0, 8'h00, 3, 20, 0, 1, 5, 8'h5C};
        vecs[2] = '{K_BOTH, 23'h000010, 8'h3C, 1'b0, 8'h00, 2,  8, 0, 1, 4, 8'h5C};
        vecs[3] = '{K_RD,   23'h000000, 8'h00, 1'b1, 8'h81, 1,  6, 1, 0, 3, 8'h81};
        vecs[4] = '{K_RD,   23'h7FFFFF, 8'h00, 1'b0, 8'h00, 6, 12, 1, 0, 8, 8'hA5};
        vecs[5] = '{K_RD,   23'h000010, 8'h00, 1'b0, 8'h00, 2,  8, 1, 0, 4, 8'h3C};

        reset = 1'b1;
        cpu_addr = '0; cpu_din = '0; cpu_idle();
        dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        ram_dout = '0; ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk_reset_values("por");
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre) begin
                env_mem[vecs[i].addr] = vecs[i].preval;
                ref_mem[vecs[i].addr] = vecs[i].preval;
            end
            cpu_access(vecs[i].kind, vecs[i].addr, vecs[i].din, vecs[i].delay, vecs[i].hold,
                       nrd, nwe, nlow);
            chk($sformatf("vec%0d_rd_pulses", i), nrd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_we_pulses", i), nwe, vecs[i].exp_we);
            chk($sformatf("vec%0d_rdy_low", i), nlow, vecs[i].exp_low);
            chk($sformatf("vec%0d_ram_addr", i), last_addr, vecs[i].addr);
            if (vecs[i].kind != K_RD) begin
                chk($sformatf("vec%0d_ram_din", i), last_din, vecs[i].din);
                ref_mem[vecs[i].addr] = vecs[i].din;
            end
            chk($sformatf("vec%0d_cpu_dout", i), cpu_dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_cpu_rdy", i), cpu_rdy, 1);
            $display("vec %0d kind=%0d addr=%06h rd=%0d we=%0d low=%0d dout=%02h",
                     i, vecs[i].kind, vecs[i].addr, nrd, nwe, nlow, cpu_dout);
        end

        // Download burst into a busy SDRAM, with a CPU read strobe that must be ignored.
        rd0 = rd_pulses;
        we0 = we_pulses;
        base = wr_log.size();
        rdy_viol = 0;
        resp_delay = 10;
        dl_active = 1'b1;
        cycle();
        cpu_addr = 23'h000555; cpu_n_cs = 1'b0; cpu_n_oe = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dl_wr = 1'b1;
            dl_addr = 23'h000100 + 23'(k);
            dl_data = 8'hD0 + 8'(k);
            cycle();
            if (!cpu_rdy) rdy_viol++;
            if (k == 2) chk("dl_stall_after_push3", dl_stall, 0);
            $display("dl push %0d addr=%06h data=%02h stall=%0b ovf=%0b",
                     k, dl_addr, dl_data, dl_stall, dl_overflow);
        end
        dl_wr = 1'b0;
        chk("dl_stall_after_push6", dl_stall, 1);
        chk("dl_overflow_set", dl_overflow, 1);
        cycle();
        dl_active = 1'b0;
        guard = 0;
        while ((we_pulses - we0 < 5 || resp_busy) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("dl_drain_in_time", (guard < 200), 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("dl_write_count", we_pulses - we0, 5);
        chk("dl_cpu_read_ignored", rd_pulses - rd0, 0);
        chk("dl_cpu_rdy_high", rdy_viol, 0);
        chk("dl_stall_drained", dl_stall, 0);
        for (int k = 0; k < 5; k++) begin
            ea = 23'h000100 + 23'(k);
            ref_mem[ea] = 8'hD0 + 8'(k);
            if (wr_log.size() > base + k)
                chk($sformatf("dl_order%0d", k), wr_log[base + k], {ea, 8'hD0 + 8'(k)});
            else
                chk($sformatf("dl_order%0d_missing", k), 0, 1);
        end
        cpu_idle();
        cycle();
        cycle();
        dl_active = 1'b1;
        cycle();
        chk("dl_overflow_cleared", dl_overflow, 0);
        dl_active = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Random CPU traffic against the byte-store reference.
        for (int t = 0; t < 40; t++) begin
            int kind, delay;
            kind  = $urandom_range(0, 2);
            delay = $urandom_range(1, 6);
            if (kind == K_RD && written.size() > 0 && $urandom_range(0, 1) == 1)
                a = written[$urandom_range(0, written.size() - 1)];
            else
                a = 23'($urandom);
            d = 8'($urandom);
            cpu_access(kind, a, d, delay, delay + 3 + $urandom_range(0, 3), nrd, nwe, nlow);
            chk($sformatf("rnd%0d_rdy_low", t), nlow, delay + 2);
            chk($sformatf("rnd%0d_ram_addr", t), last_addr, a);
            if (kind == K_RD) begin
                chk($sformatf("rnd%0d_pulses", t), {nrd[15:0], nwe[15:0]}, {16'd1, 16'd0});
                chk($sformatf("rnd%0d_cpu_dout", t), cpu_dout, ref_rd(a));
            end else begin
                chk($sformatf("rnd%0d_pulses", t), {nrd[15:0], nwe[15:0]}, {16'd0, 16'd1});
                chk($sformatf("rnd%0d_ram_din", t), last_din, d);
                ref_mem[a] = d;
                written.push_back(a);
            end
            $display("rnd %0d kind=%0d addr=%06h din=%02h delay=%0d low=%0d dout=%02h",
                     t, kind, a, d, delay, nlow, cpu_dout);
        end

`ifdef SRAM_BRIDGE_TIMEOUT_EN
        // SDRAM never answers: the watchdog must end the read after TMO WAIT cycles.
        resp_delay = 0;
        cpu_access(K_RD, 23'h000321, 8'h00, 0, 15, nrd, nwe, nlow);
        resp_busy = 0;
        chk("tmo_rd_pulses", nrd, 1);
        chk("tmo_ram_err", ram_err, 1);
        chk("tmo_cpu_dout", cpu_dout, 8'hFF);
        chk("tmo_cpu_rdy", cpu_rdy, 1);
        $display("timeout read err=%0b dout=%02h rdy=%0b", ram_err, cpu_dout, cpu_rdy);
`endif

        // Reset in the middle of WAIT, followed by a stale ram_ready.
        resp_delay = 0;
        rd0 = rd_pulses;
        we0 = we_pulses;
        cpu_addr = 23'h000ABC; cpu_n_cs = 1'b0; cpu_n_oe = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (rd_pulses != rd0) seen = 1;
        end
        chk("mid_wait_request_seen", seen, 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("mid_wait_rdy_low", cpu_rdy, 0);
        resp_busy = 0;
        rd0 = rd_pulses;
        reset = 1'b1;
        cpu_idle();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        ram_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk_reset_values("late_ready");
        chk("late_ready_no_request", (rd_pulses - rd0) + (we_pulses - we0), 0);
        $display("reset mid-wait dout=%02h rdy=%0b addr=%06h", cpu_dout, cpu_rdy, ram_addr);

        chk("never_rd_and_we", both_err, 0);
        chk("addr_din_stable", stable_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
